// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: diff = A - B - bin, one digit per clock, LSD first.
// Optional BCD_SUB_NEGMAG_EN: negative results are re-negated to a magnitude with neg=1.
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  bout,
    output logic                  neg,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [IW-1:0] FIN_IDX  = IW'(DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        NEGFIX,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic            rdy_q;
    logic [W-1:0]    a_q, b_q, diff_q;
    logic [IW-1:0]   idx_q;
    logic            brw_q;
    logic            bout_q, neg_q, err_q;

    logic [4:0]      t;
    logic [3:0]      d;
    logic            brw_n;
    logic [W-1:0]    dext;
    logic [W-1:0]    diff_shift;
    logic            accept;
    logic            last;
    logic            fin;

    function automatic logic has_nonbcd(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

    assign accept = in_valid && in_ready;
    assign last   = (idx_q == LAST_IDX);
    assign fin    = (idx_q == FIN_IDX);

    // Operands shift right so the active digit is always the low nibble;
    // result digits enter at the top and end up LSD-aligned after DIGITS shifts.
    always_comb begin
        t          = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0000, brw_q};
        brw_n      = t[4];
        d          = t[4] ? (t[3:0] + 4'd10) : t[3:0];
        dext       = '0;
        dext[W-1 -: 4] = d;
        diff_shift = (diff_q >> 4) | dext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN: begin
                if (fin) begin
`ifdef BCD_SUB_NEGMAG_EN
                    state_d = brw_q ? NEGFIX : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef BCD_SUB_NEGMAG_EN
            NEGFIX: if (last) state_d = DONE;
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            idx_q  <= '0;
            brw_q  <= 1'b0;
            bout_q <= 1'b0;
            neg_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q    <= a;
                        b_q    <= b;
                        brw_q  <= bin;
                        idx_q  <= '0;
                        err_q  <= has_nonbcd(a) | has_nonbcd(b);
                        bout_q <= 1'b0;
                        neg_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!fin) begin
                        a_q    <= a_q >> 4;
                        b_q    <= b_q >> 4;
                        diff_q <= diff_shift;
                        brw_q  <= brw_n;
                        idx_q  <= idx_q + 1'b1;
                    end else begin
                        bout_q <= brw_q;
                        neg_q  <= brw_q;
`ifdef BCD_SUB_NEGMAG_EN
                        // Negative wrap 10^N - |v| is re-subtracted from zero to yield |v|.
                        if (brw_q) begin
                            a_q   <= '0;
                            b_q   <= diff_q;
                            brw_q <= 1'b0;
                            idx_q <= '0;
                        end
`endif
                    end
                end
`ifdef BCD_SUB_NEGMAG_EN
                NEGFIX: begin
                    a_q    <= a_q >> 4;
                    b_q    <= b_q >> 4;
                    diff_q <= diff_shift;
                    brw_q  <= brw_n;
                    idx_q  <= idx_q + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready  = rdy_q && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign neg       = neg_q;
    assign err       = err_q;

endmodule
